// File: rtl/gg_vector.sv
// gg_vector: unfolded CORDIC vectoring cell emitting D_WIDTH rotation directions per cycle
//   params : D_WIDTH (directions per cycle), DATA_WIDTH (signed Q9.10 sample width)
//   inputs : clk, rst_n (async active-low), a_ij/valid_i (sample), clear_i (sync column restart)
//   outputs: d_o/d_valid_o (direction groups), rii_o/rii_valid_o (gain-compensated diagonal), busy_o
//   macro  : GG_SAT_EN selects saturating arithmetic; otherwise results wrap
module gg_vector #(
  parameter int D_WIDTH    = 4,
  parameter int DATA_WIDTH = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] a_ij,
  input  logic                         valid_i,
  input  logic                         clear_i,
  output logic        [D_WIDTH-1:0]    d_o,
  output logic                         d_valid_o,
  output logic signed [DATA_WIDTH-1:0] rii_o,
  output logic                         rii_valid_o,
  output logic                         busy_o
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam logic signed [DATA_WIDTH-1:0] sat_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] sat_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH+10:0] k_gain = 621;
  state_t state, state_n;
  logic [1:0] g;
  logic r_valid;
  logic signed [DATA_WIDTH-1:0] x, y, r, rii_n;
  logic signed [DATA_WIDTH-1:0] xs [D_WIDTH+1];
  logic signed [DATA_WIDTH-1:0] ys [D_WIDTH+1];
  logic [D_WIDTH-1:0] dv;
  // Results are formed one bit wider than the sample; the top-two-bit test detects overflow.
  function automatic logic signed [DATA_WIDTH-1:0] fit(input logic signed [DATA_WIDTH:0] v);
`ifdef GG_SAT_EN
    return (v[DATA_WIDTH] != v[DATA_WIDTH-1]) ? (v[DATA_WIDTH] ? sat_min : sat_max) : v[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction
  assign xs[0] = x;
  assign ys[0] = y;
  for (genvar k = 0; k < D_WIDTH; k++) begin : g_rot
    logic [7:0] s;
    logic signed [DATA_WIDTH:0] xe, ye;
    assign s = 8'(int'(g) * D_WIDTH + k);
    assign xe = {xs[k][DATA_WIDTH-1], xs[k]};
    assign ye = {ys[k][DATA_WIDTH-1], ys[k]};
    assign dv[k] = ~ys[k][DATA_WIDTH-1];
    assign xs[k+1] = fit(dv[k] ? xe + (ye >>> s) : xe - (ye >>> s));
    assign ys[k+1] = fit(dv[k] ? ye - (xe >>> s) : ye + (xe >>> s));
  end
  assign rii_n = fit((DATA_WIDTH+1)'((x * k_gain) >>> 10));
  assign busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    if (clear_i) state_n = IDLE;
    else if (state == IDLE) state_n = (valid_i && r_valid) ? ITER : IDLE;
    else if (state == ITER) state_n = (g == 2'd2) ? DONE : ITER;
    else state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g           <= '0;
      r_valid     <= 1'b0;
      x           <= '0;
      y           <= '0;
      r           <= '0;
      d_o         <= '0;
      d_valid_o   <= 1'b0;
      rii_o       <= '0;
      rii_valid_o <= 1'b0;
    end else begin
      state       <= state_n;
      d_valid_o   <= 1'b0;
      rii_valid_o <= 1'b0;
      if (clear_i) begin
        r_valid <= 1'b0;
        g       <= '0;
      end else if (state == IDLE && valid_i && !r_valid) begin
        r           <= a_ij;
        r_valid     <= 1'b1;
        rii_o       <= a_ij;
        rii_valid_o <= 1'b1;
      end else if (state == IDLE && valid_i) begin
        x <= r;
        y <= a_ij;
        g <= '0;
      end else if (state == ITER) begin
        x         <= xs[D_WIDTH];
        y         <= ys[D_WIDTH];
        d_o       <= dv;
        d_valid_o <= 1'b1;
        g         <= (g == 2'd2) ? 2'd0 : g + 2'd1;
      end else if (state == DONE) begin
        r           <= x;
        rii_o       <= rii_n;
        rii_valid_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gg_vector.sv
// tb_gg_vector: directed self-checking bench for gg_vector
module tb_gg_vector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [19:0] a_ij = '0;
  logic valid_i = 1'b0;
  logic clear_i = 1'b0;
  logic [3:0] d_o;
  logic d_valid_o;
  logic signed [19:0] rii_o;
  logic rii_valid_o;
  logic busy_o;
  int n_cmp = 0;
  int n_fail = 0;
  gg_vector #(.D_WIDTH(4), .DATA_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .a_ij(a_ij), .valid_i(valid_i), .clear_i(clear_i),
    .d_o(d_o), .d_valid_o(d_valid_o), .rii_o(rii_o), .rii_valid_o(rii_valid_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #12;
    n_cmp++;
    if ({d_o, d_valid_o, rii_o, rii_valid_o, busy_o} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got d=%b dv=%b rii=%0d rv=%b busy=%b want all 0", d_o, d_valid_o, rii_o, rii_valid_o, busy_o);
    end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_first_sample;
    valid_i = 1'b1; a_ij = 20'sd1024;
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== 20'sd1024) begin
      n_fail++;
      $display("FAIL first_rii got rv=%b rii=%0d want rv=1 rii=1024", rii_valid_o, rii_o);
    end
    n_cmp++;
    if (d_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL first_no_rot got dv=%b busy=%b want 0 0", d_valid_o, busy_o);
    end
    step();
    n_cmp++;
    if (rii_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pulse got rv=%b want 0", rii_valid_o);
    end
  endtask
  task automatic test_rotation;
    logic [3:0] exp_d [3];
    exp_d[0] = 4'b0011; exp_d[1] = 4'b1000; exp_d[2] = 4'b1111;
    valid_i = 1'b1; a_ij = 20'sd1024;
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1 || d_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_accept got busy=%b dv=%b want 1 0", busy_o, d_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (d_valid_o !== 1'b1 || d_o !== exp_d[i]) begin
        n_fail++;
        $display("FAIL rot_group%0d got dv=%b d=%b want dv=1 d=%b", i, d_valid_o, d_o, exp_d[i]);
      end
    end
    step();
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== 20'sd1446 || d_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rot_rii got rv=%b rii=%0d dv=%b busy=%b want rv=1 rii=1446 dv=0 busy=0", rii_valid_o, rii_o, d_valid_o, busy_o);
    end
    step();
    n_cmp++;
    if (rii_valid_o !== 1'b0 || rii_o !== 20'sd1446 || d_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL rot_hold got rv=%b rii=%0d d=%b want rv=0 rii=1446 d=1111", rii_valid_o, rii_o, d_o);
    end
  endtask
  task automatic test_back_to_back;
    int n_rii, n_dv;
    logic signed [19:0] vals [4];
    n_rii = 0; n_dv = 0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    valid_i = 1'b1; a_ij = 20'sd1024;
    for (int i = 0; i < 22; i++) begin
      step();
      if (i == 11) valid_i = 1'b0;
      if (d_valid_o) n_dv++;
      if (rii_valid_o) begin
        if (n_rii < 4) vals[n_rii] = rii_o;
        n_rii++;
      end
    end
    n_cmp++;
    if (n_rii != 4) begin
      n_fail++;
      $display("FAIL b2b_rii_count got %0d want 4", n_rii);
    end
    n_cmp++;
    if (n_dv != 9) begin
      n_fail++;
      $display("FAIL b2b_dvalid_count got %0d want 9", n_dv);
    end
    n_cmp++;
    if (vals[0] !== 20'sd1024 || vals[1] !== 20'sd1446) begin
      n_fail++;
      $display("FAIL b2b_values got %0d %0d want 1024 1446", vals[0], vals[1]);
    end
  endtask
  task automatic test_clear;
    int n_rii;
    n_rii = 0;
    valid_i = 1'b1; a_ij = 20'sd1024;
    step();
    valid_i = 1'b0;
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || d_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_abort got busy=%b dv=%b want 0 0", busy_o, d_valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (rii_valid_o) n_rii++;
    end
    n_cmp++;
    if (n_rii != 0) begin
      n_fail++;
      $display("FAIL clear_no_rii got %0d want 0", n_rii);
    end
    valid_i = 1'b1; a_ij = -20'sd512;
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== -20'sd512 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_reinit got rv=%b rii=%0d busy=%b want rv=1 rii=-512 busy=0", rii_valid_o, rii_o, busy_o);
    end
    clear_i = 1'b1; valid_i = 1'b1; a_ij = 20'sd100;
    step();
    clear_i = 1'b0;
    n_cmp++;
    if (rii_valid_o !== 1'b0 || busy_o !== 1'b0 || rii_o !== -20'sd512) begin
      n_fail++;
      $display("FAIL clear_wins got rv=%b busy=%b rii=%0d want rv=0 busy=0 rii=-512", rii_valid_o, busy_o, rii_o);
    end
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== 20'sd100 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_first_again got rv=%b rii=%0d busy=%b want rv=1 rii=100 busy=0", rii_valid_o, rii_o, busy_o);
    end
  endtask
  task automatic test_reset_mid;
    valid_i = 1'b1; a_ij = 20'sd1024;
    step();
    valid_i = 1'b0;
    step();
    n_cmp++;
    if (busy_o !== 1'b1 || d_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre got busy=%b dv=%b want 1 1", busy_o, d_valid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({d_o, d_valid_o, rii_o, rii_valid_o, busy_o} !== 27'd0) begin
      n_fail++;
      $display("FAIL mid_reset got d=%b dv=%b rii=%0d rv=%b busy=%b want all 0", d_o, d_valid_o, rii_o, rii_valid_o, busy_o);
    end
    #3 rst_n = 1'b1;
    valid_i = 1'b1; a_ij = 20'sd300;
    step();
    valid_i = 1'b0;
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== 20'sd300 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_first got rv=%b rii=%0d busy=%b want rv=1 rii=300 busy=0", rii_valid_o, rii_o, busy_o);
    end
  endtask
  task automatic test_saturation;
    logic [3:0] exp_d0;
    logic signed [19:0] exp_rii;
`ifdef GG_SAT_EN
    exp_d0 = 4'b0011; exp_rii = 20'sd317951;
`else
    exp_d0 = 4'b1111; exp_rii = -20'sd2;
`endif
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    valid_i = 1'b1; a_ij = 20'sd524287;
    step();
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== 20'sd524287) begin
      n_fail++;
      $display("FAIL sat_first got rv=%b rii=%0d want rv=1 rii=524287", rii_valid_o, rii_o);
    end
    step();
    valid_i = 1'b0;
    step();
    n_cmp++;
    if (d_valid_o !== 1'b1 || d_o !== exp_d0) begin
      n_fail++;
      $display("FAIL sat_group0 got dv=%b d=%b want dv=1 d=%b", d_valid_o, d_o, exp_d0);
    end
    step();
    step();
    step();
    n_cmp++;
    if (rii_valid_o !== 1'b1 || rii_o !== exp_rii) begin
      n_fail++;
      $display("FAIL sat_rii got rv=%b rii=%0d want rv=1 rii=%0d", rii_valid_o, rii_o, exp_rii);
    end
  endtask
  initial begin
    test_reset();
    test_first_sample();
    test_rotation();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
